// File: rtl/mac_pkg.sv
// Shared fixed-point types and defaults for the MAC output path.
// Q8.8 samples are produced from Q16.16 accumulator results.
package mac_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  typedef logic signed [15:0] q88_t;
  typedef logic signed [31:0] acc_t;

  localparam q88_t Q88_MAX = 16'sh7FFF;
  localparam q88_t Q88_MIN = 16'sh8000;

endpackage

// File: rtl/mac_requant_out_if.sv
// Handshake bundle for mac_requant_out: accumulator input side, Q8.8 output side
// and the saturation statistics. slave is the block's view, master the driver's.
interface mac_requant_out_if
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic signed [2*WIDTH-1:0] acc_in;
  logic                      acc_valid;
  logic                      acc_ready;
  logic signed [WIDTH-1:0]   q_out;
  logic                      q_sat;
  logic                      q_valid;
  logic                      q_ready;
  logic                      clr_stats;
  logic [15:0]               sat_cnt;

  modport master (
    output acc_in, acc_valid, q_ready, clr_stats,
    input  acc_ready, q_out, q_sat, q_valid, sat_cnt
  );

  modport slave (
    input  acc_in, acc_valid, q_ready, clr_stats,
    output acc_ready, q_out, q_sat, q_valid, sat_cnt
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push and pop may coincide
// at any fill level, and a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DEF_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mac_requant_out.sv
// Requantises Q16.16 accumulator results to saturated Q8.8 and buffers them.
// Build option MAC_REQUANT_ROUND_EN selects round-half-up instead of floor.
module mac_requant_out
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_requant_out_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 2*WIDTH + 1;
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MAC_REQUANT_ROUND_EN
  localparam logic signed [SW-1:0] ROUND_HALF = SW'(1) << (FRAC-1);
`endif

  logic                    s1_v_q, s1_v_d;
  logic signed [SW-1:0]    s1_acc_q, s1_acc_d;
  logic                    s2_v_q, s2_v_d;
  logic signed [WIDTH-1:0] s2_val_q, s2_val_d;
  logic                    s2_sat_q, s2_sat_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;

  logic                    acc_ready;
  logic                    in_fire;
  logic signed [SW-1:0]    acc_ext;
  logic signed [SW-1:0]    shifted;
  logic [WIDTH+1:0]        shifted_hi;
  logic                    in_range;
  logic [CW:0]             credit_used;

  logic                    fifo_pop;
  logic [WIDTH:0]          fifo_rdata;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;

  // Credits cover everything already committed downstream, so S1/S2 never
  // need to stall; a pop in the current cycle only frees a credit next cycle.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
  assign acc_ready   = credit_used < (CW+1)'(DEPTH);
  assign in_fire     = bus.acc_valid && acc_ready;
  assign acc_ext     = {bus.acc_in[2*WIDTH-1], bus.acc_in};

  // Result fits when every bit above the output MSB matches the sign.
  assign shifted    = s1_acc_q >>> FRAC;
  assign shifted_hi = shifted[SW-1:WIDTH-1];
  assign in_range   = (&shifted_hi) || !(|shifted_hi);

  always_comb begin
    s1_v_d   = in_fire;
    s1_acc_d = s1_acc_q;
    if (in_fire) begin
`ifdef MAC_REQUANT_ROUND_EN
      s1_acc_d = acc_ext + ROUND_HALF;
`else
      s1_acc_d = acc_ext;
`endif
    end
  end

  always_comb begin
    s2_v_d   = s1_v_q;
    s2_val_d = s2_val_q;
    s2_sat_d = s2_sat_q;
    if (s1_v_q) begin
      s2_sat_d = !in_range;
      if (in_range) begin
        s2_val_d = shifted[WIDTH-1:0];
      end else if (shifted[SW-1]) begin
        s2_val_d = SAT_MIN;
      end else begin
        s2_val_d = SAT_MAX;
      end
    end
  end

  // A clear in the same cycle as a saturated push leaves the count at zero.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (bus.clr_stats) begin
      sat_cnt_d = '0;
    end else if (s2_v_q && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_acc_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_val_q  <= '0;
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_acc_q  <= s1_acc_d;
      s2_v_q    <= s2_v_d;
      s2_val_q  <= s2_val_d;
      s2_sat_q  <= s2_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign fifo_pop = bus.q_ready && !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_v_q),
    .wdata ({s2_sat_q, s2_val_q}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The credit scheme guarantees S2 never lands on a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (!rst_n) !(s2_v_q && fifo_full && !fifo_pop));

  assign bus.acc_ready = acc_ready;
  assign bus.q_valid   = !fifo_empty;
  assign bus.q_out     = fifo_empty ? '0 : fifo_rdata[WIDTH-1:0];
  assign bus.q_sat     = fifo_empty ? 1'b0 : fifo_rdata[WIDTH];
  assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_mac_requant_out.sv
// Randomised and directed bench for mac_requant_out against a plain-arithmetic
// requantisation model and a queue scoreboard; honours MAC_REQUANT_ROUND_EN.
module tb_mac_requant_out;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_requant_out_if #(.WIDTH(16)) bus ();

  mac_requant_out #(.WIDTH(16), .FRAC(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] exp_q [$];
  int          exp_sat_cnt = 0;

`ifdef MAC_REQUANT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  // Reference: value/256 rounded (half up) or floored, then clamped to Q8.8.
  function automatic logic [16:0] ref_requant(input logic [31:0] a);
    longint v;
    v = longint'(acc_t'(a));
    if (ROUND) v = v + 128;
    v = v >>> 8;
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  // One clock: drive inputs, report which transfers happen at the coming edge.
  task automatic tick(input bit v, input logic [31:0] d, input bit r,
                      output bit took_in, output bit took_out, output logic [16:0] word);
    bus.acc_valid = v;
    bus.acc_in    = d;
    bus.q_ready   = r;
    took_in  = v && (bus.acc_ready === 1'b1);
    took_out = (bus.q_valid === 1'b1) && r;
    word     = {bus.q_sat, bus.q_out};
    if (took_in) begin
      logic [16:0] e;
      e = ref_requant(d);
      exp_q.push_back(e);
      if (e[16] && exp_sat_cnt < 65535) exp_sat_cnt++;
    end
    @(posedge clk);
    #1;
    bus.acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ti, to;
    logic [16:0] w;
    rst_n = 1'b0;
    bus.acc_valid = 1'b0; bus.acc_in = '0; bus.q_ready = 1'b0; bus.clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%b want=0", bus.q_valid); end
    checks++; if (bus.q_out !== 16'h0) begin failures++; $display("FAIL reset_q_out got=%h want=0000", bus.q_out); end
    checks++; if (bus.q_sat !== 1'b0) begin failures++; $display("FAIL reset_q_sat got=%b want=0", bus.q_sat); end
    checks++; if (bus.sat_cnt !== 16'h0) begin failures++; $display("FAIL reset_sat_cnt got=%h want=0000", bus.sat_cnt); end
    checks++; if (bus.acc_ready !== 1'b1) begin failures++; $display("FAIL reset_acc_ready got=%b want=1", bus.acc_ready); end
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b0, ti, to, w);
    checks++; if (bus.acc_ready !== 1'b1) begin failures++; $display("FAIL post_reset_acc_ready got=%b want=1", bus.acc_ready); end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [31:0] din [5];
    logic [16:0] want [5];
    bit ti, to;
    logic [16:0] w;
    int n;
    din = '{32'h0000_0180, 32'hFFFF_FE80, 32'h0100_0000, 32'h8000_0000, 32'h007F_FF80};
`ifdef MAC_REQUANT_ROUND_EN
    want = '{17'h0_0002, 17'h0_FFFF, 17'h1_7FFF, 17'h1_8000, 17'h1_7FFF};
`else
    want = '{17'h0_0001, 17'h0_FFFE, 17'h1_7FFF, 17'h1_8000, 17'h0_7FFF};
`endif
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, din[i], 1'b1, ti, to, w);
      checks++; if (!ti) begin failures++; $display("FAIL directed_accept[%0d] got=0 want=1", i); end
      n = 0;
      to = 1'b0;
      while (!to && n < 6) begin
        tick(1'b0, '0, 1'b1, ti, to, w);
        n++;
      end
      checks++; if (!to) begin failures++; $display("FAIL directed_timeout[%0d] got=no_output want=output", i); end
      checks++; if (n != 3) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=3", i, n); end
      checks++; if (w !== want[i]) begin failures++; $display("FAIL directed_value[%0d] in=%h got=%h want=%h", i, din[i], w, want[i]); end
      if (to && exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (bus.sat_cnt !== 16'(exp_sat_cnt)) begin failures++; $display("FAIL directed_sat_cnt[%0d] got=%0d want=%0d", i, bus.sat_cnt, exp_sat_cnt); end
      $display("directed in=%h out=%h latency=%0d sat_cnt=%0d", din[i], w, n, bus.sat_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ti, to;
    logic [16:0] w;
    logic [16:0] want;
    int k = 1;
    int j = 0;
    int guard = 0;
    bit check_ready_next = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(k <= 6, 32'(k) << 16, 1'b0, ti, to, w);
      if (ti) k++;
    end
    checks++; if (k - 1 != 4) begin failures++; $display("FAIL bp_accepted got=%0d want=4", k - 1); end
    checks++; if (bus.acc_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b want=0", bus.acc_ready); end
    while (j < 6 && guard < 30) begin
      if (check_ready_next) begin
        checks++; if (bus.acc_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return got=%b want=1", bus.acc_ready); end
        check_ready_next = 1'b0;
      end
      tick(k <= 6, 32'(k) << 16, 1'b1, ti, to, w);
      if (ti) k++;
      if (to) begin
        want = 17'((j + 1) << 8);
        checks++; if (w !== want) begin failures++; $display("FAIL bp_order[%0d] got=%h want=%h", j, w, want); end
        $display("backpressure out[%0d]=%h", j, w);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        j++;
        if (j == 1) check_ready_next = 1'b1;
      end
      guard++;
    end
    checks++; if (j != 6) begin failures++; $display("FAIL bp_count got=%0d want=6", j); end
  endtask

  task automatic test_clear();
    bit ti, to;
    logic [16:0] w;
    bus.clr_stats = 1'b1;
    tick(1'b0, '0, 1'b1, ti, to, w);
    bus.clr_stats = 1'b0;
    exp_sat_cnt = 0;
    checks++; if (bus.sat_cnt !== 16'h0) begin failures++; $display("FAIL clr_alone got=%h want=0000", bus.sat_cnt); end
    tick(1'b1, 32'h0100_0000, 1'b1, ti, to, w);
    tick(1'b0, '0, 1'b1, ti, to, w);
    bus.clr_stats = 1'b1;
    tick(1'b0, '0, 1'b1, ti, to, w);
    bus.clr_stats = 1'b0;
    exp_sat_cnt = 0;
    checks++; if (bus.sat_cnt !== 16'h0) begin failures++; $display("FAIL clr_with_push got=%h want=0000", bus.sat_cnt); end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) tick(1'b1, 32'h8000_0000, 1'b1, ti, to, w);
      else        tick(1'b0, '0, 1'b1, ti, to, w);
      if (to) begin
        checks++;
        if (exp_q.size() == 0 || w !== exp_q[0]) begin
          failures++; $display("FAIL clr_output got=%h want=%h", w, (exp_q.size() > 0) ? exp_q[0] : 17'h0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++; if (bus.sat_cnt !== 16'(exp_sat_cnt)) begin failures++; $display("FAIL clr_recount got=%0d want=%0d", bus.sat_cnt, exp_sat_cnt); end
    $display("clear sat_cnt=%0d", bus.sat_cnt);
  endtask

  task automatic test_random();
    bit ti, to, v, r;
    logic [16:0] w;
    logic [31:0] d, rnd;
    int outs = 0;
    for (int c = 0; c < 400 + 20; c++) begin
      v = (c < 400) && ($urandom_range(0, 3) != 0);
      r = (c >= 400) || ($urandom_range(0, 3) != 0);
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0: d = rnd;
        1: d = {{8{rnd[23]}}, rnd[23:0]};
        2: d = 32'h007F_FF00 + 32'($urandom_range(0, 255));
        default: d = 32'hFF7F_FF80 + 32'($urandom_range(0, 255));
      endcase
      checks++; if (bus.acc_ready !== (exp_q.size() < 4)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, bus.acc_ready, exp_q.size() < 4); end
      if (bus.q_valid !== 1'b1) begin
        checks++; if ({bus.q_sat, bus.q_out} !== 17'h0) begin failures++; $display("FAIL rand_idle_out cyc=%0d got=%h want=00000", c, {bus.q_sat, bus.q_out}); end
      end else begin
        checks++; if (exp_q.size() == 0) begin failures++; $display("FAIL rand_spurious cyc=%0d got=valid want=empty", c); end
      end
      tick(v, d, r, ti, to, w);
      if (to && exp_q.size() > 0) begin
        checks++; if (w !== exp_q[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, w, exp_q[0]); end
        $display("random out[%0d]=%h", outs, w);
        void'(exp_q.pop_front());
        outs++;
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d want=0", exp_q.size()); end
    checks++; if (bus.sat_cnt !== 16'(exp_sat_cnt)) begin failures++; $display("FAIL rand_sat_cnt got=%0d want=%0d", bus.sat_cnt, exp_sat_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ti, to;
    logic [16:0] w;
    for (int c = 0; c < 6; c++) tick(c < 3, 32'h7FFF_FFFF, 1'b0, ti, to, w);
    checks++; if (bus.q_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered got=%b want=1", bus.q_valid); end
    checks++; if (bus.sat_cnt !== 16'(exp_sat_cnt)) begin failures++; $display("FAIL mid_pre_cnt got=%0d want=%0d", bus.sat_cnt, exp_sat_cnt); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_sat_cnt = 0;
    checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL mid_q_valid got=%b want=0", bus.q_valid); end
    checks++; if (bus.acc_ready !== 1'b1) begin failures++; $display("FAIL mid_acc_ready got=%b want=1", bus.acc_ready); end
    checks++; if (bus.sat_cnt !== 16'h0) begin failures++; $display("FAIL mid_sat_cnt got=%h want=0000", bus.sat_cnt); end
    checks++; if ({bus.q_sat, bus.q_out} !== 17'h0) begin failures++; $display("FAIL mid_q_out got=%h want=00000", {bus.q_sat, bus.q_out}); end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.q_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b want=0", c, bus.q_valid); end
      tick(1'b0, '0, 1'b1, ti, to, w);
    end
    $display("reset_mid done sat_cnt=%0d", bus.sat_cnt);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_clear();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_requant_out.md
# mac_requant_out

Output stage for the MAC accumulator. Accepts full-width Q16.16 accumulator results over a valid/ready handshake, rounds and saturates them back to Q8.8, and buffers them in a small FIFO for a downstream valid/ready consumer. It also flags and counts every saturated sample. It sits between the MAC accumulator and the writeback/next-layer logic.

## Interface
- WIDTH, 16: output sample width. Q8.8, signed.
- FRAC, 8: fractional bits of the output. Input has 2*FRAC fractional bits.
- DEPTH, 4: output FIFO entries. Power of two, ≥ 4.
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- acc_in  in  2*WIDTH  signed accumulator value, Q16.16.
- acc_valid  in  1  acc_in valid.
- acc_ready  out  1  block can take acc_in.
- q_out  out  WIDTH  signed Q8.8 result at the FIFO head.
- q_sat  out  1  head sample was saturated.
- q_valid  out  1  FIFO non-empty.
- q_ready  in  1  consumer takes the head.
- clr_stats  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  16  saturated-sample count. Saturates at 0xFFFF.

## Operation
- Input transfer occurs on a clock edge with acc_valid && acc_ready. Output transfer occurs with q_valid && q_ready.
- The pipeline has three steps:
  - S1 register: captures the input transfer. With rounding enabled, it also sign-extends acc_in to 2*WIDTH+1 bits and adds 2^(FRAC-1).
  - S2 register: arithmetic right shift by FRAC, then saturation to [-32768, 32767].
  - FIFO push: {sat, value} is written into the FIFO.
- S1 and S2 never stall. Flow control is by credit:
  - acc_ready = (fifo_count + s1_v + s2_v) < DEPTH, computed from registered state only.
  - A pop in the same cycle is not credited.
- sat_cnt increments by 1 on each FIFO push with sat=1, and holds at 0xFFFF.
- clr_stats zeroes sat_cnt. If clr_stats coincides with a saturated push, the clear wins (result 0).
- The FIFO supports simultaneous push and pop at any count, including when empty. Data order is preserved.
- When q_valid=0, q_out and q_sat are forced to 0.
- Reset values:
  - q_valid=0, q_out=0, q_sat=0, sat_cnt=0.
  - s1_v=0, s2_v=0, FIFO empty.
  - acc_ready=1 while held in reset and immediately after.
- Reset mid-operation discards all in-flight and buffered samples. No partial output appears.

## Timing
- Latency: an input transfer at edge T gives q_valid=1 after edge T+2 if the FIFO was empty.
- Throughput: one sample per cycle sustained while q_ready=1.
- acc_ready deasserts the cycle after the credit limit is reached. It reasserts the cycle after a pop frees a credit.
- q_valid and q_out are registered (FIFO state). There is no combinational path from acc_* to q_*.
- The only combinational input-to-output path is q_ready → none. acc_ready depends on registers only.

## Configuration
- MAC_REQUANT_ROUND_EN defined: round-half-up, i.e. add 2^(FRAC-1) before the shift. The carry can cause saturation.
- Undefined: truncation (floor via arithmetic shift). The S1 adder is removed; S1 only registers.
- Latency and handshake are identical in both builds.

## Structure
- mac_pkg holds:
  - WIDTH and FRAC defaults.
  - Typedefs q88_t (signed [15:0]) and acc_t (signed [31:0]).
  - Constants Q88_MAX=16'sh7FFF and Q88_MIN=16'sh8000.
- One sub-module, sync_fifo: parameterised DEPTH and data width WIDTH+1. It exposes push, pop, count, empty, full and head data.
- The rounding, saturation and credit logic live in mac_requant_out.

## Test plan
- Rounding. Input 0x0000_0180 → q_out 0x0002 with ROUND_EN, 0x0001 without; q_sat=0 in both builds.
- Negative rounding. Input 0xFFFF_FE80 → 0xFFFF with ROUND_EN, 0xFFFE without.
- Saturation. Inputs 0x0100_0000 → 0x7FFF, q_sat=1; then 0x8000_0000 → 0x8000, q_sat=1; sat_cnt=2.
- Rounding carry. Input 0x007F_FF80 → 0x7FFF with q_sat=1 under ROUND_EN; 0x7FFF with q_sat=0 without.
- Backpressure. Hold q_ready=0 and offer inputs 1..6 back-to-back (values k<<16):
  - exactly 4 are accepted, then acc_ready=0;
  - release q_ready → outputs 0x0100, 0x0200, 0x0300, 0x0400 in order;
  - the remaining 2 are then accepted and output in order.
- Reset and clear:
  - assert rst_n=0 with 3 samples buffered → q_valid=0 and acc_ready=1 immediately, sat_cnt=0, no stale output after release;
  - clr_stats pulsed together with a saturated push → sat_cnt=0.
